cfg_mode_switch_ctrl: RTL and testbench
=======================================

CFG_MODE_SWITCH_CTRL -- requirements
Module: cfg_mode_switch_ctrl

Interface
REQ-001 SHALL have parameter CVA6Cfg, default config_pkg::cva6_cfg_empty, the static build-time core configuration.
REQ-002 SHALL have parameter NrFeatures, default 8, the number of runtime-switchable feature channels (1..32).
REQ-003 SHALL have parameter FeatCapMask, default all ones, NrFeatures bits: the features present in hardware.
REQ-004 SHALL have parameter FeatRstMask, default all ones, NrFeatures bits: the features enabled after reset.
REQ-005 SHALL have parameter DrainTimeout, default 64, the maximum number of drain-wait cycles (>=1).
REQ-006 SHALL have ports, one per line:
  clk_i  in  1  clock;
  rst_ni  in  1  reset, synchronous, active-low;
  req_valid_i  in  1  new configuration request;
  req_ready_o  out  1  request accepted when high with valid;
  req_feat_i  in  NrFeatures  requested feature enables;
  req_mode_i  in  2  requested CHERI mode: 0 off, 1 hybrid, 2 purecap, 3 reserved;
  flush_o  out  1  one-cycle pipeline flush request;
  drained_i  in  1  pipeline empty and commit idle;
  rsp_valid_o  out  1  response valid;
  rsp_ready_i  in  1  response consumed;
  rsp_code_o  out  2  0 OK, 1 MASKED, 2 UNSUPPORTED, 3 TIMEOUT;
  feat_active_o  out  NrFeatures  effective feature enables;
  mode_o  out  2  effective CHERI mode;
  busy_o  out  1  high in any state other than IDLE.

Function
REQ-007 SHALL implement the FSM states IDLE, FLUSH, DRAIN, APPLY and RESP.
REQ-008 IDLE: req_ready_o=1; on valid&ready, latch the request, run the legality check, and go to FLUSH (legal) or RESP (illegal).
REQ-009 Legality: mode 3, or mode 2 without CVA6Cfg.RVZcheripurecap, or mode 1 without CVA6Cfg.RVZcherihybrid, or mode 0 with CVA6Cfg.RVZcheripurecap and without CVA6Cfg.RVZcherihybrid -> UNSUPPORTED; no flush, no state change.
REQ-010 Legal request with req_feat_i & ~FeatCapMask nonzero: the SHALL proceed with masked features (req_feat_i & FeatCapMask); final code MASKED, otherwise OK.
REQ-011 FLUSH: flush_o=1 for exactly one cycle, then go to DRAIN; flush_o SHALL be 0 in all other states.
REQ-012 DRAIN: an 8-bit-minimum counter ($clog2(DrainTimeout+1) bits) SHALL count cycles from 0; drained_i=1 -> APPLY; counter reaching DrainTimeout with drained_i=0 -> RESP with TIMEOUT, no apply.
REQ-013 drained_i=1 on the same cycle the counter reaches DrainTimeout -> APPLY (drain wins).
REQ-014 APPLY: feat_active_o and mode_o SHALL update on the clock edge leaving APPLY (visible the cycle RESP is entered); one cycle; then RESP.
REQ-015 RESP: rsp_valid_o=1, rsp_code_o stable until rsp_ready_i=1; on that handshake return to IDLE; rsp_valid_o=0 outside RESP.
REQ-016 Latency with drained_i held high: accept cycle T, flush_o at T+1, DRAIN at T+2, APPLY at T+3, rsp_valid_o at T+4.
REQ-017 Requests SHALL NOT be accepted while busy_o=1 (req_ready_o=0); no queuing.
REQ-018 A request equal to the current configuration SHALL still perform flush/drain/apply (idempotent).
REQ-019 feat_active_o bits outside FeatCapMask SHALL always be 0.

Reset
REQ-020 On rst_ni=0 at a clock edge: state IDLE, counter 0, flush_o=0, rsp_valid_o=0, rsp_code_o=0, busy_o=0.
REQ-021 Reset values: feat_active_o = FeatRstMask & FeatCapMask; mode_o = 2 if RVZcheripurecap, else 1 if RVZcherihybrid, else 0.
REQ-022 Reset mid-operation (any state) SHALL abandon the transaction with no response and restore the REQ-021 values.

Structure
REQ-023 The mode and response-code enums, the FSM state typedef and the reset-mode function SHALL live in a shared package cfg_mode_pkg.
REQ-024 The drain counter SHALL be a sub-module cfg_drain_timer (start, hit, expired).
REQ-025 The block SHALL be purely single-clock with all outputs registered except req_ready_o and busy_o (decoded from state).

Verification
REQ-026 Purecap+hybrid cfg, NrFeatures=8, FeatCapMask=0x0F; request mode 1, feat 0x05, drained_i=1 -> flush at T+1, rsp OK at T+4, feat_active_o=0x05, mode_o=1.
REQ-027 Same cfg; request feat 0xF3 -> feat_active_o=0x03, code MASKED.
REQ-028 Cfg without RVZcheripurecap; request mode 2 -> no flush, response at T+1 UNSUPPORTED, outputs unchanged.
REQ-029 DrainTimeout=4, drained_i=0 -> TIMEOUT response, outputs unchanged; repeat with drained_i rising on the 4th DRAIN cycle -> OK.
REQ-030 Hold rsp_ready_i=0 for 10 cycles -> response stable, req_ready_o=0; assert rst_ni=0 in DRAIN -> REQ-021 values next cycle, no response.

Source files
------------

// File: rtl/cfg_mode_pkg.sv
// rtl/cfg_mode_pkg.sv - shared types and helpers for the runtime mode/feature switch
package cfg_mode_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_HYBRID  = 2'd1,
    MODE_PURECAP = 2'd2,
    MODE_RSVD    = 2'd3
  } cheri_mode_e;

  typedef enum logic [1:0] {
    RSP_OK          = 2'd0,
    RSP_MASKED      = 2'd1,
    RSP_UNSUPPORTED = 2'd2,
    RSP_TIMEOUT     = 2'd3
  } rsp_code_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FLUSH = 3'd1,
    S_DRAIN = 3'd2,
    S_APPLY = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  function automatic cheri_mode_e reset_mode(input logic purecap, input logic hybrid);
    if (purecap)     return MODE_PURECAP;
    else if (hybrid) return MODE_HYBRID;
    else             return MODE_OFF;
  endfunction

  // A purecap-only core cannot drop capabilities entirely, so OFF is refused there.
  function automatic logic mode_supported(input cheri_mode_e mode, input logic purecap,
                                          input logic hybrid);
    case (mode)
      MODE_OFF:     return !(purecap && !hybrid);
      MODE_HYBRID:  return hybrid;
      MODE_PURECAP: return purecap;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - static core build configuration consumed by the mode switch controller
package config_pkg;

  typedef struct packed {
    logic RVZcheripurecap;
    logic RVZcherihybrid;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{RVZcheripurecap: 1'b0, RVZcherihybrid: 1'b0};

endpackage

// File: rtl/cfg_drain_timer.sv
// rtl/cfg_drain_timer.sv - bounded wait counter for the pipeline drain phase
module cfg_drain_timer #(
  parameter int unsigned DrainTimeout = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_start,
  input  logic i_hit,
  output logic o_expired
);

  localparam int unsigned CntW = ($clog2(DrainTimeout + 1) > 8) ? $clog2(DrainTimeout + 1) : 8;
  localparam logic [CntW-1:0] LastCnt = CntW'(DrainTimeout - 1);

  logic [CntW-1:0] r_cnt;

  // Expired marks the DrainTimeout-th wait cycle; the caller lets a drain on that cycle win.
  assign o_expired = (r_cnt == LastCnt);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_hit && !o_expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cfg_mode_switch_ctrl.sv
// rtl/cfg_mode_switch_ctrl.sv - flush/drain/apply sequencer for runtime CHERI mode and feature changes
module cfg_mode_switch_ctrl
  import cfg_mode_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t  CVA6Cfg      = config_pkg::cva6_cfg_empty,
  parameter int unsigned            NrFeatures   = 8,
  parameter logic [NrFeatures-1:0]  FeatCapMask  = '1,
  parameter logic [NrFeatures-1:0]  FeatRstMask  = '1,
  parameter int unsigned            DrainTimeout = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [NrFeatures-1:0] req_feat_i,
  input  logic [1:0]            req_mode_i,
  output logic                  flush_o,
  input  logic                  drained_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [1:0]            rsp_code_o,
  output logic [NrFeatures-1:0] feat_active_o,
  output logic [1:0]            mode_o,
  output logic                  busy_o
);

  localparam logic [NrFeatures-1:0] FeatRst = FeatRstMask & FeatCapMask;
  localparam cheri_mode_e ModeRst = reset_mode(CVA6Cfg.RVZcheripurecap, CVA6Cfg.RVZcherihybrid);

  state_e                r_state;
  state_e                w_state_nxt;
  rsp_code_e             r_rsp_code;
  rsp_code_e             w_rsp_code_nxt;
  logic                  r_flush;
  logic                  r_rsp_valid;
  logic [NrFeatures-1:0] r_feat;
  logic [NrFeatures-1:0] r_req_feat;
  cheri_mode_e           r_mode;
  cheri_mode_e           r_req_mode;
  logic                  r_masked;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_expired;

  assign req_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign w_accept      = req_valid_i && req_ready_o;
  assign w_legal       = mode_supported(cheri_mode_e'(req_mode_i),
                                        CVA6Cfg.RVZcheripurecap, CVA6Cfg.RVZcherihybrid);
  assign flush_o       = r_flush;
  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_code_o    = r_rsp_code;
  assign feat_active_o = r_feat;
  assign mode_o        = r_mode;

  cfg_drain_timer #(
    .DrainTimeout(DrainTimeout)
  ) u_drain_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_start  (r_state == S_FLUSH),
    .i_hit    (r_state == S_DRAIN),
    .o_expired(w_expired)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_rsp_code_nxt = r_rsp_code;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_legal) begin
            w_state_nxt = S_FLUSH;
          end else begin
            w_state_nxt    = S_RESP;
            w_rsp_code_nxt = RSP_UNSUPPORTED;
          end
        end
      end
      S_FLUSH: w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (drained_i) begin
          w_state_nxt = S_APPLY;
        end else if (w_expired) begin
          w_state_nxt    = S_RESP;
          w_rsp_code_nxt = RSP_TIMEOUT;
        end
      end
      S_APPLY: begin
        w_state_nxt    = S_RESP;
        w_rsp_code_nxt = r_masked ? RSP_MASKED : RSP_OK;
      end
      S_RESP: begin
        if (rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pulse and response outputs are registered from the next state so they align with it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_flush     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_code  <= RSP_OK;
      r_feat      <= FeatRst;
      r_mode      <= ModeRst;
      r_req_feat  <= '0;
      r_req_mode  <= MODE_OFF;
      r_masked    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush     <= (w_state_nxt == S_FLUSH);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_rsp_code  <= w_rsp_code_nxt;
      if (w_accept) begin
        r_req_feat <= req_feat_i & FeatCapMask;
        r_req_mode <= cheri_mode_e'(req_mode_i);
        r_masked   <= |(req_feat_i & ~FeatCapMask);
      end
      if (r_state == S_APPLY) begin
        r_feat <= r_req_feat;
        r_mode <= r_req_mode;
      end
    end
  end

endmodule

// File: tb/tb_cfg_mode_switch_ctrl.sv
// tb/tb_cfg_mode_switch_ctrl.sv - self-checking bench for cfg_mode_switch_ctrl against a transaction-level model
module tb_cfg_mode_switch_ctrl;

  localparam config_pkg::cva6_cfg_t CFG_A = '{RVZcheripurecap: 1'b1, RVZcherihybrid: 1'b1};
  localparam config_pkg::cva6_cfg_t CFG_B = '{RVZcheripurecap: 1'b0, RVZcherihybrid: 1'b1};

  logic [7:0] cap_m [2];
  logic [7:0] rst_m [2];
  logic       pc_m  [2];
  logic       hy_m  [2];
  int         tmo_m [2];
  logic [7:0] m_feat [2];
  logic [1:0] m_mode [2];

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [7:0]      req_feat;
  logic [1:0]      req_mode;
  logic            drained;
  logic            rsp_ready;
  logic [1:0]      req_ready_w;
  logic [1:0]      flush_w;
  logic [1:0]      rsp_valid_w;
  logic [1:0]      busy_w;
  logic [1:0][1:0] code_w;
  logic [1:0][7:0] feat_w;
  logic [1:0][1:0] mode_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cfg_mode_switch_ctrl #(
    .CVA6Cfg(CFG_A), .NrFeatures(8), .FeatCapMask(8'h0F), .FeatRstMask(8'hFF), .DrainTimeout(4)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(req_ready_w[0]),
    .req_feat_i(req_feat), .req_mode_i(req_mode), .flush_o(flush_w[0]), .drained_i(drained),
    .rsp_valid_o(rsp_valid_w[0]), .rsp_ready_i(rsp_ready), .rsp_code_o(code_w[0]),
    .feat_active_o(feat_w[0]), .mode_o(mode_w[0]), .busy_o(busy_w[0])
  );

  cfg_mode_switch_ctrl #(
    .CVA6Cfg(CFG_B), .NrFeatures(8), .FeatCapMask(8'h3C), .FeatRstMask(8'h25), .DrainTimeout(6)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(req_ready_w[1]),
    .req_feat_i(req_feat), .req_mode_i(req_mode), .flush_o(flush_w[1]), .drained_i(drained),
    .rsp_valid_o(rsp_valid_w[1]), .rsp_ready_i(rsp_ready), .rsp_code_o(code_w[1]),
    .feat_active_o(feat_w[1]), .mode_o(mode_w[1]), .busy_o(busy_w[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_feat[d] = rst_m[d] & cap_m[d];
      m_mode[d] = pc_m[d] ? 2'd2 : (hy_m[d] ? 2'd1 : 2'd0);
    end
  endfunction

  task automatic check_idle(input int d, input string tag);
    check({tag, "_feat"},  {24'd0, feat_w[d]}, {24'd0, m_feat[d]});
    check({tag, "_mode"},  {30'd0, mode_w[d]}, {30'd0, m_mode[d]});
    check({tag, "_busy"},  {31'd0, busy_w[d]}, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready_w[d]}, 32'd1);
    check({tag, "_rspv"},  {31'd0, rsp_valid_w[d]}, 32'd0);
    check({tag, "_flush"}, {31'd0, flush_w[d]}, 32'd0);
  endtask

  // drain_at: DRAIN cycle (1-based) on which drained rises; 0 means it never does.
  task automatic txn(input int d, input logic [1:0] mode, input logic [7:0] feat,
                     input int drain_at, input int hold);
    int c, rsp_at, fc, n_fl, exp_lat, exp_fc, exp_fl;
    logic legal;
    logic [1:0] exp_code;
    legal = (mode == 2'd1 && hy_m[d]) || (mode == 2'd2 && pc_m[d]) ||
            (mode == 2'd0 && (hy_m[d] || !pc_m[d]));
    if (!legal) begin
      exp_lat = 1; exp_fc = -1; exp_fl = 0; exp_code = 2'd2;
    end else if (drain_at >= 1 && drain_at <= tmo_m[d]) begin
      exp_lat = 3 + drain_at; exp_fc = 1; exp_fl = 1;
      exp_code = ((feat & ~cap_m[d]) != 8'd0) ? 2'd1 : 2'd0;
      m_feat[d] = feat & cap_m[d];
      m_mode[d] = mode;
    end else begin
      exp_lat = 2 + tmo_m[d]; exp_fc = 1; exp_fl = 1; exp_code = 2'd3;
    end
    req_valid[d] = 1'b1; req_mode = mode; req_feat = feat; drained = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    c = 1; rsp_at = -1; fc = -1; n_fl = 0;
    while (c <= 100) begin
      drained = (drain_at > 0) && (c >= 1 + drain_at);
      if (flush_w[d]) begin
        n_fl++;
        if (fc < 0) fc = c;
      end
      if (rsp_valid_w[d]) begin
        rsp_at = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    check("rsp_latency", rsp_at, exp_lat);
    check("flush_cycle", fc, exp_fc);
    check("flush_count", n_fl, exp_fl);
    if (rsp_at > 0) begin
      check("rsp_code",   {30'd0, code_w[d]}, {30'd0, exp_code});
      check("rsp_feat",   {24'd0, feat_w[d]}, {24'd0, m_feat[d]});
      check("rsp_mode",   {30'd0, mode_w[d]}, {30'd0, m_mode[d]});
      check("rsp_busy",   {31'd0, busy_w[d]}, 32'd1);
      check("rsp_ready",  {31'd0, req_ready_w[d]}, 32'd0);
      for (int h = 0; h < hold; h++) begin
        req_valid[d] = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        check("hold_valid", {31'd0, rsp_valid_w[d]}, 32'd1);
        check("hold_code",  {30'd0, code_w[d]}, {30'd0, exp_code});
        check("hold_ready", {31'd0, req_ready_w[d]}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      drained = 1'b0;
      check_idle(d, "post");
    end else begin
      drained = 1'b0;
    end
  endtask

  initial begin
    cap_m = '{8'h0F, 8'h3C};
    rst_m = '{8'hFF, 8'h25};
    pc_m  = '{1'b1, 1'b0};
    hy_m  = '{1'b1, 1'b1};
    tmo_m = '{4, 6};
    model_reset();
    rst_n = 1'b0; req_valid = 2'b00; req_feat = '0; req_mode = '0; drained = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(0, "rst_a");
    check_idle(1, "rst_b");

    txn(0, 2'd1, 8'h05, 1, 0);
    txn(0, 2'd1, 8'hF3, 1, 0);
    txn(0, 2'd1, 8'hF3, 1, 0);
    txn(1, 2'd2, 8'h3C, 1, 0);
    txn(1, 2'd3, 8'h00, 1, 0);
    txn(0, 2'd0, 8'h0A, 0, 0);
    txn(0, 2'd0, 8'h0A, 4, 0);
    txn(0, 2'd2, 8'h06, 1, 10);
    txn(1, 2'd0, 8'hFF, 6, 2);

    req_valid[0] = 1'b1; req_mode = 2'd1; req_feat = 8'h09; drained = 1'b0;
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_idle(0, "mid_rst_a");
    check_idle(1, "mid_rst_b");
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_norsp", {31'd0, rsp_valid_w[0]}, 32'd0);
    end

    for (int i = 0; i < 40; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      txn(d, 2'($urandom_range(0, 3)), 8'($urandom), int'($urandom_range(0, tmo_m[d] + 2)),
          int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
